// File: rtl/preg_free_list.sv
// rtl/preg_free_list.sv - rename-stage physical register free list
// Circular FIFO of unmapped pregs with per-register mapped tracking to reject illegal frees.
module preg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    localparam int TAG_W = $clog2(NUM_PREGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_alloc_req,
    output logic             o_alloc_gnt,
    output logic [TAG_W-1:0] o_alloc_preg,
    input  logic             i_free_valid,
    input  logic [TAG_W-1:0] i_free_preg,
    output logic [TAG_W:0]   o_free_count,
    output logic             o_empty,
    output logic             o_free_err
);

    localparam int DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] L_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] L_LAST = PTR_W'(DEPTH - 1);

    logic [TAG_W-1:0]     r_entry [DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [NUM_PREGS-1:0] r_mapped;
    logic                 r_empty;
    logic                 r_free_err;

    logic                 w_gnt;
    logic [TAG_W-1:0]     w_head_preg;
    logic                 w_free_nz;
    logic                 w_free_ok;
    logic                 w_free_bad;
    logic [PTR_W-1:0]     w_head_nxt;
    logic [PTR_W-1:0]     w_tail_nxt;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [NUM_PREGS-1:0] w_mapped_nxt;

    assign w_head_preg = r_entry[r_head];
    assign w_gnt       = i_alloc_req & ~r_empty;

    // p0 frees are dropped silently; legality uses pre-edge mapped state and count
    assign w_free_nz  = i_free_valid & (i_free_preg != '0);
    assign w_free_ok  = w_free_nz & r_mapped[i_free_preg] & (r_count != L_FULL);
    assign w_free_bad = w_free_nz & ~w_free_ok;

    assign w_head_nxt = (r_head == L_LAST) ? '0 : r_head + 1'b1;
    assign w_tail_nxt = (r_tail == L_LAST) ? '0 : r_tail + 1'b1;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_gnt, w_free_ok})
            2'b10:   w_count_nxt = r_count - 1'b1;
            2'b01:   w_count_nxt = r_count + 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_mapped_nxt = r_mapped;
        if (w_free_ok) begin
            w_mapped_nxt[i_free_preg] = 1'b0;
        end
        if (w_gnt) begin
            w_mapped_nxt[w_head_preg] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= TAG_W'(NUM_AREGS + i);
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= L_FULL;
            r_mapped   <= {{DEPTH{1'b0}}, {NUM_AREGS{1'b1}}};
            r_empty    <= 1'b0;
            r_free_err <= 1'b0;
        end else begin
            if (w_free_ok) begin
                r_entry[r_tail] <= i_free_preg;
                r_tail          <= w_tail_nxt;
            end
            if (w_gnt) begin
                r_head <= w_head_nxt;
            end
            r_count    <= w_count_nxt;
            r_mapped   <= w_mapped_nxt;
            r_empty    <= (w_count_nxt == '0);
            r_free_err <= w_free_bad;
        end
    end

    assign o_alloc_gnt  = w_gnt;
    assign o_alloc_preg = w_head_preg;
    assign o_free_count = (TAG_W + 1)'(r_count);
    assign o_empty      = r_empty;
    assign o_free_err   = r_free_err;

endmodule

// File: doc/preg_free_list.md
# preg_free_list

Physical-register free-list controller for the rename stage. Holds the pool of unmapped physical registers as a circular FIFO and hands one to the rename logic per cycle through a request/grant handshake. Takes back one retired (previous-mapping) register per cycle from the retire stage. Tracks per-register allocation state so that illegal frees are rejected and flagged rather than corrupting the pool.

## Interface

- NUM_PREGS, 64, number of physical registers; tag width is log2(NUM_PREGS)
- NUM_AREGS, 32, number of architectural registers; p0..p(NUM_AREGS-1) are mapped at reset
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- alloc_req  input  1  rename stage needs a destination physical register this cycle
- alloc_gnt  output  1  allocation granted this cycle (combinational)
- alloc_preg  output  6  physical register at FIFO head; valid when alloc_gnt=1
- free_valid  input  1  retire stage returns a physical register this cycle
- free_preg  input  6  register being returned (the old destination mapping)
- free_count  output  7  number of registers currently in the free list (registered)
- empty  output  1  free_count==0; rename must stall (registered)
- free_err  output  1  one-cycle registered pulse: the previous cycle's free was rejected

## Operation

- **Storage**
  - FIFO of NUM_PREGS-NUM_AREGS=32 entries, 6 bits each.
  - 5-bit head and tail pointers.
  - 6-bit count, 0..32.
  - 64-bit mapped vector: 1 = register mapped or in flight.
- **Reset**
  - entry[i]=32+i; head=0; tail=0; count=32.
  - mapped[31:0]=1; mapped[63:32]=0.
  - Outputs after reset: alloc_gnt=alloc_req, alloc_preg=32, free_count=32, empty=0, free_err=0.
- **Allocate**
  - alloc_gnt = alloc_req & ~empty.
  - alloc_preg = entry[head], driven regardless of alloc_req.
  - On a granted edge: head+=1 (wraps 31→0), mapped[alloc_preg]=1, count-=1.
- **Free**
  - Accepted when free_valid & free_preg!=0 & mapped[free_preg]=1 & count<32.
  - On acceptance: entry[tail]=free_preg, tail+=1 (wraps 31→0), mapped[free_preg]=0, count+=1.
- **p0 (x0's register)**
  - p0 is never in the FIFO and is never allocated.
  - free_preg==0 is silently ignored: no error.
- **Rejected free**
  - Triggered by free_valid with preg!=0 and either mapped[preg]=0 (double free) or count==32 (overflow).
  - The free is dropped and no state changes.
  - free_err=1 on the next cycle only.
- **Simultaneous alloc and free, not empty**
  - Both take effect.
  - count is unchanged.
  - The freed entry is written at tail; the granted entry is read from head.
- **Simultaneous alloc and free, empty**
  - No bypass: alloc_gnt=0.
  - The freed register is pushed and becomes grantable the next cycle.
- **Same register allocated and freed in one cycle**: impossible while not empty, because an allocated register is not yet mapped before the edge. If attempted, the free is checked against pre-edge mapped state.
- **Invariants**
  - count == (tail-head) mod 32, except count==32 with head==tail, which means full.
  - popcount(~mapped[63:1]) == count.

## Timing

- Allocation has zero-cycle latency: the grant and register are visible in the same cycle as alloc_req. The register leaves the pool at that cycle's edge.
- A register freed at edge N can be allocated in cycle N+1 at the earliest, once it reaches head.
- free_count and empty reflect all grants and frees up to the last edge.
- free_err is asserted in the cycle after the offending free_valid and lasts exactly one cycle.
- rst takes priority over every other input in the same cycle. A reset asserted mid-stream discards all pending state and restores the reset image on the next edge. alloc_gnt may still be 1 in the reset cycle, but nothing is committed.

## Test plan

- **Reset then single allocations**: rst for 2 cycles, then alloc_req=1 for 3 cycles → alloc_preg 32,33,34 with alloc_gnt=1; free_count 32→29.
- **Drain to empty**: alloc_req=1 for 33 cycles → grants for p32..p63; cycle 33 has alloc_gnt=0 and empty=1; free_count=0.
- **Empty with simultaneous free**: while empty, free p5 with alloc_req=1 → alloc_gnt=0 that cycle; next cycle alloc_gnt=1, alloc_preg=5, free_count 1→0.
- **Double free and overflow**:
  - Free p40 while p40 is in the pool → free_err pulse next cycle; count unchanged.
  - Free p7 at count==32 after reset → free_err pulse; state unchanged.
  - Free p0 → no error, no change.
- **Steady state with wrap**: alloc_req=1 and free_valid=1 every cycle for 100 cycles, freeing the register granted 4 cycles earlier → alloc_gnt always 1; free_count constant at 28 after warm-up; pointers wrap; granted sequence matches a reference FIFO model.
- **Reset mid-operation**: after 10 grants and 3 frees, assert rst for 1 cycle → next cycle free_count=32, alloc_preg=32, free_err=0, and a free of p40 is accepted as illegal (free_err).
